// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU constants and fetch-path types
package cpu_pkg;

    localparam int XLEN        = 32;
    localparam int INSTR_BYTES = 4;

    // addi x0, x0, 0: harmless filler shown to decode before anything is fetched
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    // One prefetched instruction together with the byte address it came from
    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    localparam fetch_entry_t RESET_ENTRY = '{pc: '0, instr: NOP_INSTR};

    // Fetch addresses are always whole instruction words
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - redirect, instruction ROM and decode-side signals of the fetch unit
interface instr_fetch_if;
    import cpu_pkg::*;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic [XLEN-1:0] imem_rdata;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_instr;
    logic [XLEN-1:0] out_pc;

    // Fetch unit side
    modport master (
        input  redirect_valid,
        input  redirect_pc,
        input  imem_rdata,
        input  out_ready,
        output imem_req,
        output imem_addr,
        output out_valid,
        output out_instr,
        output out_pc
    );

    // Core / ROM side
    modport slave (
        output redirect_valid,
        output redirect_pc,
        output imem_rdata,
        output out_ready,
        input  imem_req,
        input  imem_addr,
        input  out_valid,
        input  out_instr,
        input  out_pc
    );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular prefetch buffer of {pc, instr} entries with flush
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t push_entry_i,
    input  logic         pop_i,
    output fetch_entry_t head_o,
    output logic [2:0]   count_o
);

    localparam int PW = (DEPTH > 2) ? 2 : 1;

    fetch_entry_t    mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [2:0]      count_q, count_d;
    logic            do_push;
    logic            do_pop;

    // Pointers wrap at DEPTH, which need not be a power of two
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Flush beats everything; a full buffer still accepts a push when it is popped
    always_comb begin
        do_pop   = pop_i && (count_q != 3'd0) && !flush_i;
        do_push  = push_i && !flush_i && ((count_q != 3'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 3'd1;
                2'b01:   count_d = count_q - 3'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; reset contents make the idle head read as a NOP at pc 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= RESET_ENTRY;
            end
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry_i;
        end
    end

    // Head comes straight from storage, so a push is only visible next cycle
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - instruction fetch unit with credit-limited prefetch and redirect flush
module instr_fetch
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    instr_fetch_if.master bus
);

    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic            inflight_q, inflight_d;
    logic [XLEN-1:0] inflight_pc_q, inflight_pc_d;

    logic [2:0]      count;
    fetch_entry_t    head;
    fetch_entry_t    push_entry;
    logic            out_valid;
    logic            pop;
    logic            push;
    logic            issue;

    // Issue/accept decisions; an entry being popped this cycle frees a credit
    // immediately so the ROM can be read every cycle in steady state
    always_comb begin
        out_valid     = (count != 3'd0) && !bus.redirect_valid;
        pop           = out_valid && bus.out_ready;
        issue         = rst_n && !bus.redirect_valid &&
                        ((int'(count) + int'(inflight_q)) < (DEPTH + int'(pop)));
        push          = inflight_q && !bus.redirect_valid;
        push_entry    = '{pc: inflight_pc_q, instr: bus.imem_rdata};
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = inflight_pc_q;
        if (bus.redirect_valid) begin
            fetch_pc_d = word_align(bus.redirect_pc);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
        end
        if (issue) begin
            inflight_pc_d = fetch_pc_q;
        end
    end

    // Fetch address and the single outstanding ROM read
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= word_align(RESET_PC);
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
        end
    end

    // A redirect flushes buffered words; the response landing that cycle is dropped too
    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush_i      (bus.redirect_valid),
        .push_i       (push),
        .push_entry_i (push_entry),
        .pop_i        (pop),
        .head_o       (head),
        .count_o      (count)
    );

    assign bus.imem_req  = issue;
    assign bus.imem_addr = fetch_pc_q;
    assign bus.out_valid = out_valid;
    assign bus.out_instr = head.instr;
    assign bus.out_pc    = head.pc;

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - self-checking bench for instr_fetch
module tb_instr_fetch;
    import cpu_pkg::*;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    instr_fetch_if bus ();

    instr_fetch #(
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // ROM contents: word i holds the value i
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {2'b00, a[31:2]};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ROM answers one cycle after the strobe; garbage otherwise
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= rom_word(bus.imem_addr);
        else              bus.imem_rdata <= 32'hDEAD_BEEF;
    end

    // Stream model: requests and emitted instructions each walk word by word from the
    // last restart point; nothing stale may appear and nothing may be skipped
    logic [31:0] m_rpc, m_opc, prev_pc, prev_instr;
    int          m_issued, m_popped;
    bit          have_prev;

    always @(negedge clk) begin
        if (!rst_n) begin
            m_rpc     = RESET_PC & 32'hFFFF_FFFC;
            m_opc     = RESET_PC & 32'hFFFF_FFFC;
            m_issued  = 0;
            m_popped  = 0;
            have_prev = 1'b0;
        end else if (bus.redirect_valid) begin
            chk("redirect_out_valid", 32'(bus.out_valid), 32'd0);
            chk("redirect_imem_req", 32'(bus.imem_req), 32'd0);
            m_rpc     = bus.redirect_pc & 32'hFFFF_FFFC;
            m_opc     = bus.redirect_pc & 32'hFFFF_FFFC;
            m_issued  = 0;
            m_popped  = 0;
            have_prev = 1'b0;
        end else begin
            if (have_prev) begin
                chk("hold_valid", 32'(bus.out_valid), 32'd1);
                chk("hold_pc", bus.out_pc, prev_pc);
                chk("hold_instr", bus.out_instr, prev_instr);
            end
            if (bus.imem_req) begin
                chk("imem_addr", bus.imem_addr, m_rpc);
                m_rpc = m_rpc + 32'd4;
                m_issued++;
            end
            if (bus.out_valid) begin
                chk("out_pc", bus.out_pc, m_opc);
                chk("out_instr", bus.out_instr, rom_word(m_opc));
                if (bus.out_ready) begin
                    m_opc = m_opc + 32'd4;
                    m_popped++;
                end
            end
            chk("credit", 32'((m_issued - m_popped) <= DEPTH), 32'd1);
            have_prev  = bus.out_valid && !bus.out_ready;
            prev_pc    = bus.out_pc;
            prev_instr = bus.out_instr;
        end
    end

    logic [31:0] seen [3];
    logic [31:0] last_pc;
    int          n;
    int          pops;

    initial begin
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.out_ready      = 1'b1;
        seen[0] = 32'hBAD0_BAD0;
        seen[1] = 32'hBAD0_BAD0;
        seen[2] = 32'hBAD0_BAD0;
        last_pc = 32'hBAD0_BAD0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_imem_req", 32'(bus.imem_req), 32'd0);
        chk("rst_out_instr", bus.out_instr, 32'h0000_0013);
        chk("rst_out_pc", bus.out_pc, 32'h0);

        // Fill: one request per cycle, first instruction two cycles later
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            chk("fill_req", 32'(bus.imem_req), 32'd1);
            chk("fill_addr", bus.imem_addr, 32'(4 * k));
            if (k < 2) begin
                chk("fill_valid_lo", 32'(bus.out_valid), 32'd0);
            end else begin
                chk("fill_valid", 32'(bus.out_valid), 32'd1);
                chk("fill_pc", bus.out_pc, 32'(4 * (k - 2)));
                chk("fill_instr", bus.out_instr, 32'(k - 2));
            end
            step();
        end

        // Stall for 10 cycles from a fresh stream at 0
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        #1;
        n = 0;
        for (int k = 0; k < 10; k++) begin
            if (bus.imem_req) n++;
            step();
        end
        chk("stall_reqs", 32'(n), 32'(DEPTH));
        chk("stall_valid", 32'(bus.out_valid), 32'd1);
        chk("stall_pc", bus.out_pc, 32'h0);
        bus.out_ready = 1'b1;
        #1;
        pops = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.out_valid && bus.out_ready) begin
                pops++;
                last_pc = bus.out_pc;
            end
            step();
        end
        chk("resume_pops", 32'(pops), 32'd6);
        chk("resume_last_pc", last_pc, 32'h14);

        // Redirect with one read in flight and the credit exhausted
        bus.out_ready      = 1'b0;
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0;
        step();
        bus.redirect_valid = 1'b0;
        step();
        step();
        chk("pre_redirect_valid", 32'(bus.out_valid), 32'd1);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0040;
        bus.out_ready      = 1'b1;
        #1;
        chk("r_valid_lo", 32'(bus.out_valid), 32'd0);
        chk("r_req_lo", 32'(bus.imem_req), 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        #1;
        chk("r1_valid_lo", 32'(bus.out_valid), 32'd0);
        chk("r1_req", 32'(bus.imem_req), 32'd1);
        chk("r1_addr", bus.imem_addr, 32'h40);
        step();
        chk("r2_valid_lo", 32'(bus.out_valid), 32'd0);
        step();
        chk("r3_valid", 32'(bus.out_valid), 32'd1);
        chk("r3_pc", bus.out_pc, 32'h40);
        chk("r3_instr", bus.out_instr, 32'h10);

        // Back-to-back redirects: last one wins
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'h0000_0100;
        step();
        bus.redirect_pc    = 32'h0000_0200;
        step();
        bus.redirect_valid = 1'b0;
        #1;
        chk("b2b_1_valid_lo", 32'(bus.out_valid), 32'd0);
        step();
        chk("b2b_2_valid_lo", 32'(bus.out_valid), 32'd0);
        step();
        chk("b2b_valid", 32'(bus.out_valid), 32'd1);
        chk("b2b_pc", bus.out_pc, 32'h200);
        chk("b2b_instr", bus.out_instr, 32'h80);

        // Address wrap, with misaligned low bits ignored
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 32'hFFFF_FFFB;
        step();
        bus.redirect_valid = 1'b0;
        #1;
        n = 0;
        for (int k = 0; k < 20 && n < 3; k++) begin
            if (bus.out_valid && bus.out_ready) begin
                seen[n] = bus.out_pc;
                n++;
            end
            step();
        end
        chk("wrap_count", 32'(n), 32'd3);
        chk("wrap_pc0", seen[0], 32'hFFFF_FFF8);
        chk("wrap_pc1", seen[1], 32'hFFFF_FFFC);
        chk("wrap_pc2", seen[2], 32'h0000_0000);

        // Reset in the middle of a stream
        step();
        chk("pre_reset_valid", 32'(bus.out_valid), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_req", 32'(bus.imem_req), 32'd0);
        chk("mid_rst_instr", bus.out_instr, 32'h0000_0013);
        chk("mid_rst_pc", bus.out_pc, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        chk("restart_req", 32'(bus.imem_req), 32'd1);
        chk("restart_addr", bus.imem_addr, RESET_PC);
        step();
        chk("restart_valid_lo", 32'(bus.out_valid), 32'd0);
        step();
        chk("restart_valid", 32'(bus.out_valid), 32'd1);
        chk("restart_pc", bus.out_pc, RESET_PC);
        chk("restart_instr", bus.out_instr, rom_word(RESET_PC));

        repeat (4) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
